// File: rtl/scr1_ahb_sram_resp.sv
// rtl/scr1_ahb_sram_resp.sv - AHB-Lite SRAM responder with wait states, ERROR response and write forwarding
module scr1_ahb_sram_resp #(
  parameter int SCR1_MEM_POWER_SIZE = 16,
  parameter int STALL_W             = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_cfg,
  input  logic               hsel,
  input  logic [31:0]        haddr,
  input  logic [1:0]         htrans,
  input  logic               hwrite,
  input  logic [2:0]         hsize,
  input  logic [31:0]        hwdata,
  input  logic               hready,
  output logic               hreadyout,
  output logic [31:0]        hrdata,
  output logic               hresp
);

  localparam int AW    = SCR1_MEM_POWER_SIZE - 2;
  localparam int WORDS = 1 << AW;

  typedef enum logic [2:0] {DP_IDLE, DP_WAIT, DP_DATA, DP_ERR1, DP_ERR2} dp_state_e;

  dp_state_e          state_q, state_d;
  logic [STALL_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [1:0]         off_q, off_d;
  logic [1:0]         size_q, size_d;
  logic               write_q, write_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [31:0]        mem [WORDS];

  logic               can_acc, acc, err, we, fwd;
  logic [AW-1:0]      idx;
  logic [3:0]         strb;
  logic [31:0]        ram_word;
  logic               unused_htrans0;

  assign unused_htrans0 = htrans[0];
  assign idx      = haddr[AW+1:2];
  assign ram_word = mem[idx];
  assign err      = (hsize > 3'd2)
                  | ((hsize == 3'd1) & haddr[0])
                  | ((hsize == 3'd2) & (haddr[1:0] != 2'b00))
                  | ((haddr >> SCR1_MEM_POWER_SIZE) != 32'd0);
  assign can_acc  = (state_q == DP_IDLE) | (state_q == DP_DATA) | (state_q == DP_ERR2);
  assign acc      = hsel & hready & htrans[1] & can_acc;
  assign we       = (state_q == DP_DATA) & write_q;
  assign fwd      = we & (idx == idx_q);

  // Little-endian lane strobes of the transfer currently in its data phase
  always_comb begin
    strb = 4'b0000;
    case (size_q)
      2'd0:    strb[off_q] = 1'b1;
      2'd1:    strb = off_q[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    off_d     = off_q;
    size_d    = size_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state_q)
      DP_WAIT: begin
        hreadyout = 1'b0;
        cnt_d     = cnt_q - STALL_W'(1);
        if (cnt_q <= STALL_W'(1)) state_d = DP_DATA;
      end
      DP_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = DP_ERR2;
      end
      DP_ERR2: hresp = 1'b1;
      default: ;
    endcase
    // IDLE, DATA and ERR2 all complete this cycle and may take a new address phase
    if (can_acc) begin
      if (acc) begin
        idx_d   = idx;
        off_d   = haddr[1:0];
        size_d  = hsize[1:0];
        write_d = hwrite & ~err;
        if (err) begin
          state_d = DP_ERR1;
        end else if (stall_cfg == '0) begin
          state_d = DP_DATA;
        end else begin
          state_d = DP_WAIT;
          cnt_d   = stall_cfg;
        end
        if (!hwrite && !err) begin
          for (int b = 0; b < 4; b++) begin
            rdata_d[8*b +: 8] = (fwd && strb[b]) ? hwdata[8*b +: 8] : ram_word[8*b +: 8];
          end
        end
      end else begin
        state_d = DP_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DP_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata = rdata_q;

endmodule
